// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e           : receiver FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DEFAULT_CLKS_PER_BIT : 50 MHz system clock / 115200 baud
//   cnt_width()          : register width needed to count 0..n-1 (at least 1 bit)
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO, shared with the TX path.
//   clk, reset : clock, asynchronous active-low reset (clears pointers)
//   push_i     : write din_i; dropped when full unless a pop happens on the same edge
//   pop_i      : advance head; ignored when empty
//   din_i      : write data
//   dout_o     : head entry, 0 when empty
//   empty_o    : no entries stored
//   full_o     : 2**ADDR_EXP entries stored
//   count_o    : number of stored entries
// Valid/ready: a push is accepted on an edge where push_i=1 and (!full_o or an
// accepted pop); a pop is accepted on an edge where pop_i=1 and !empty_o.
module uart_rx_fifo_sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_EXP   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_EXP:0]     count_o
);

  localparam int DEPTH = 2 ** ADDR_EXP;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_EXP:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_EXP:0]     rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_EXP] != rd_ptr_q[ADDR_EXP]) &&
                   (wr_ptr_q[ADDR_EXP-1:0] == rd_ptr_q[ADDR_EXP-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot the push needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_EXP-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_EXP-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a receive FIFO behind it.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   rx            : asynchronous serial line, idle high
//   rx_fifo_pop   : pop FIFO head (ignored when empty)
//   rx_byte       : FIFO head, 0 when empty
//   rx_fifo_empty : FIFO empty
//   rx_fifo_full  : FIFO full
//   rx_count      : number of stored bytes
//   irq           : data pending (= !rx_fifo_empty)
//   frame_err     : 1-cycle pulse, stop bit sampled low, byte dropped
//   overrun       : 1-cycle pulse, byte completed while FIFO full, byte dropped
//   rx_state      : receiver FSM state (debug)
// Valid/ready: the receiver offers a byte (push) for exactly one cycle at the
// stop-bit sample; the FIFO accepts it when not full or when popped that edge,
// otherwise the byte is dropped and overrun pulses.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_EXP     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  rx_fifo_pop,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_fifo_empty,
  output logic                  rx_fifo_full,
  output logic [ADDR_EXP:0]     rx_count,
  output logic                  irq,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [1:0]            rx_state
);

  localparam int TW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  push;
  logic                  timer_last;

  assign timer_last = (timer_q == T_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!rx_s_q) state_d = ST_START;
      // Mid-start-bit check: a line that has already returned high was a glitch.
      ST_START: if (timer_q == T_HALF) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (timer_last && (bit_q == B_LAST)) state_d = ST_STOP;
      ST_STOP:  if (timer_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    timer_d     = timer_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    unique case (state_q)
      ST_IDLE:  timer_d = '0;
      ST_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (timer_last) begin
          timer_d = '0;
          bit_d   = bit_q + 1'b1;
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
        end
      end
      ST_STOP: begin
        if (timer_last) begin
          timer_d     = '0;
          push        = rx_s_q;
          frame_err_d = !rx_s_q;
          // Full implies non-empty, so a pop here always frees a slot.
          overrun_d   = rx_s_q && rx_fifo_full && !rx_fifo_pop;
        end
      end
      default: timer_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      timer_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_EXP   (ADDR_EXP)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (rx_fifo_pop),
    .din_i   (shift_q),
    .dout_o  (rx_byte),
    .empty_o (rx_fifo_empty),
    .full_o  (rx_fifo_full),
    .count_o (rx_count)
  );

  assign irq       = !rx_fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_state  = state_q;

endmodule
